instr_fetch_unit: RTL and testbench

Instruction fetch front end for the RISC-V core. It owns the fetch PC, issues word requests to an instruction memory with variable response latency, and buffers returned instructions with their PCs in a small prefetch FIFO. Decode/execute consumes from that FIFO over a valid/ready handshake. A redirect from the execute stage flushes the FIFO, discards responses already in flight and restarts fetch at the new PC.

---
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Owns the fetch PC, issues word requests to an
// instruction memory whose response latency varies, and buffers the returned
// instructions together with their PCs in a small prefetch FIFO that the
// decode stage drains over a valid/ready handshake. A redirect from execute
// clears the FIFO, arranges for responses already in flight to be discarded,
// and restarts fetch at the new PC.
//
// Parameters
//   RESET_PC  fetch PC after reset (word aligned)
//   DEPTH     prefetch FIFO entries (power of two, >= 2); also caps the
//             number of requests in flight
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       request channel to instruction memory
//   imem_rsp_valid/data             in-order responses, no backpressure
//   redirect_valid/pc               one-cycle fetch restart from execute
//   instr_valid/ready/data/pc       FIFO head towards decode
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    // Architectural state
    logic [31:0] fetch_pc;   // address of the next request
    logic [31:0] rsp_pc;     // PC belonging to the next kept response
    cnt_t        inflight;   // handshaken requests still awaiting a response
    cnt_t        drop;       // responses still to be thrown away
    cnt_t        count;      // FIFO occupancy
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    entry_t      fifo_mem [DEPTH];

    // Per-cycle events
    logic        req_fire;
    logic        push;
    logic        pop;
    logic        rsp_discard;
    cnt_t        credit_used;
    logic [31:0] target_pc;

    // NOTE: every signal driven in always_comb gets a value before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        credit_used = count + inflight;
        target_pc   = redirect_pc & 32'hFFFF_FFFC;

        // Credit covers both buffered entries and responses still on their
        // way, so a response always finds a free FIFO slot. The request is
        // also withheld during reset and in a redirect cycle so that no
        // request can leave with an address that is about to be replaced.
        imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_CNT);
        imem_req_addr  = fetch_pc;

        req_fire    = imem_req_valid && imem_req_ready;
        rsp_discard = (drop != '0);
        push        = imem_rsp_valid && !redirect_valid && !rsp_discard;

        instr_valid = (count != '0);
        pop         = instr_valid && instr_ready;
        instr_pc    = fifo_mem[rd_ptr].pc;
        instr_data  = fifo_mem[rd_ptr].data;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of all the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            // Outstanding requests are tracked identically in every cycle;
            // a redirect only changes what their responses will be used for.
            inflight <= inflight + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);

            if (redirect_valid) begin
                // A response landing in this same cycle is already discarded
                // here, so it is not counted again in drop.
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop     <= inflight - cnt_t'(imem_rsp_valid);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && rsp_discard) begin
                    drop <= drop - cnt_t'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // NOTE: the storage array is reset as well, because the head entry drives
    // instr_data/instr_pc directly and those must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= '{pc: rsp_pc, data: imem_rsp_data};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. The bench plays the instruction memory (fixed
// latency, in-order, word k holds 32'h1000_0000 + k) and keeps a queue-based
// model of the front end: the FIFO is a queue of {pc, data}, outstanding
// requests carry an epoch so that a redirect simply makes everything older
// stale. Each cycle the DUT outputs are compared with that model, and
// directed scenarios pin the results with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { int cyc; logic [31:0] pc; logic [31:0] data; } pop_t;
    typedef struct { int cyc; logic [31:0] addr; } hs_t;

    req_t memq[$];     // requests accepted by the memory, oldest first
    ent_t fifo_q[$];   // expected FIFO contents, head first
    pop_t pop_log[$];  // instructions the DUT handed to the consumer
    hs_t  hs_log[$];   // request handshakes the DUT made

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          stall_checks = 0;
    bit          ir_cfg = 1'b0;
    bit          rr_rand = 1'b0;
    bit          rst_cfg = 1'b0;
    bit          redir_next = 1'b0;
    logic [31:0] redir_pc_v = 32'h0;
    logic [31:0] m_fetch_pc = RST_PC;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    logic        smp_req_valid;
    logic [31:0] smp_addr;
    logic        smp_instr_valid;
    logic        smp_rsp_valid;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then sample, compare
    // and advance the model to what the next rising edge must produce.
    task automatic cycle();
        req_t r;
        ent_t e;
        pop_t p;
        hs_t  h;
        bit   exp_rv;
        @(negedge clk);
        rst_n          = rst_cfg;
        instr_ready    = ir_cfg;
        imem_req_ready = rr_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        redirect_valid = redir_next;
        redirect_pc    = redir_pc_v;
        if (rst_n && memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        smp_req_valid   = imem_req_valid;
        smp_addr        = imem_req_addr;
        smp_instr_valid = instr_valid;
        smp_rsp_valid   = imem_rsp_valid;

        exp_rv = rst_n && !redirect_valid && (fifo_q.size() + memq.size() < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
        check("instr_valid", 32'(instr_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            check("instr_pc", instr_pc, fifo_q[0].pc);
            check("instr_data", instr_data, fifo_q[0].data);
        end
        if (!rst_n) begin
            check("rst_instr_pc", instr_pc, 32'h0);
            check("rst_instr_data", instr_data, 32'h0);
            check("rst_req_addr", imem_req_addr, RST_PC);
        end
        if (rst_n && prev_stall && imem_req_valid) begin
            check("addr_stable", imem_req_addr, prev_addr);
            stall_checks++;
        end
        prev_stall = rst_n && imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;

        if (rst_n) begin
            if (instr_valid && instr_ready) begin
                p.cyc = cyc; p.pc = instr_pc; p.data = instr_data;
                pop_log.push_back(p);
            end
            if (fifo_q.size() != 0 && instr_ready) void'(fifo_q.pop_front());
            if (imem_rsp_valid) begin
                r = memq.pop_front();
                if (!redirect_valid && r.epoch == epoch) begin
                    e.pc = r.addr; e.data = word_at(r.addr);
                    fifo_q.push_back(e);
                end
            end
            if (redirect_valid) begin
                fifo_q.delete();
                epoch++;
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (exp_rv && imem_req_ready) begin
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr; r.epoch = epoch; r.due = cyc + lat;
                memq.push_back(r);
                h.cyc = cyc; h.addr = imem_req_addr;
                hs_log.push_back(h);
            end
        end
        redir_next = 1'b0;
        cyc++;
    endtask

    // Hold reset for two cycles; cycle 0 of a test is the first cycle after
    // release.
    task automatic do_reset();
        rst_cfg = 1'b0;
        rst_n   = 1'b0;
        memq.delete();
        fifo_q.delete();
        m_fetch_pc = RST_PC;
        epoch++;
        prev_stall = 1'b0;
        repeat (2) cycle();
        cyc = 0;
        pop_log.delete();
        hs_log.delete();
        rst_cfg = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        #1 rst_n = 1'b0;

        // 1: reset release, L = 1, full throughput
        lat = 1; ir_cfg = 1'b1; rr_rand = 1'b0;
        do_reset();
        repeat (12) cycle();
        check("t1_pops", pop_log.size(), 10);
        if (hs_log.size() != 0) check("t1_first_req_cyc", hs_log[0].cyc, 0);
        for (int k = 0; k < 8 && k < pop_log.size(); k++) begin
            check("t1_pc", pop_log[k].pc, RST_PC + 32'(4 * k));
            check("t1_data", pop_log[k].data, 32'h1000_0020 + 32'(k));
            check("t1_cyc", pop_log[k].cyc, 2 + k);
        end

        // 2: consumer stalled, L = 2: credit limits to DEPTH requests
        lat = 2; ir_cfg = 1'b0;
        do_reset();
        repeat (10) cycle();
        check("t2_reqs", hs_log.size(), 4);
        for (int k = 0; k < 4 && k < hs_log.size(); k++)
            check("t2_req_addr", hs_log[k].addr, RST_PC + 32'(4 * k));
        check("t2_req_idle", 32'(smp_req_valid), 32'h0);
        check("t2_no_pop", pop_log.size(), 0);
        ir_cfg = 1'b1;
        repeat (8) cycle();
        for (int k = 0; k < 4 && k < pop_log.size(); k++) begin
            check("t2_drain_pc", pop_log[k].pc, RST_PC + 32'(4 * k));
            check("t2_drain_cyc", pop_log[k].cyc, 10 + k);
        end
        check("t2_req_count", hs_log.size() > 4, 1);
        if (hs_log.size() > 4) begin
            check("t2_next_addr", hs_log[4].addr, 32'h0000_0090);
            check("t2_resume_cyc", hs_log[4].cyc, 11);
        end

        // 3: L = 3, redirect with three requests outstanding
        lat = 3; ir_cfg = 1'b1;
        do_reset();
        repeat (3) cycle();
        check("t3_outstanding", hs_log.size(), 3);
        redir_next = 1'b1; redir_pc_v = 32'h0000_0100;
        cycle();
        repeat (10) cycle();
        check("t3_req_count", hs_log.size() > 3, 1);
        if (hs_log.size() > 3) begin
            check("t3_req_addr", hs_log[3].addr, 32'h0000_0100);
            check("t3_req_cyc", hs_log[3].cyc, 4);
        end
        check("t3_pops", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            check("t3_pc0", pop_log[0].pc, 32'h0000_0100);
            check("t3_cyc0", pop_log[0].cyc, 8);
            check("t3_pc1", pop_log[1].pc, 32'h0000_0104);
            check("t3_data1", pop_log[1].data, 32'h1000_0041);
        end

        // 4: unaligned redirect together with a response and a pop
        lat = 1; ir_cfg = 1'b1;
        do_reset();
        repeat (5) cycle();
        redir_next = 1'b1; redir_pc_v = 32'h0000_0102;
        cycle();
        check("t4_rsp_at_r", 32'(smp_rsp_valid), 32'h1);
        check("t4_pop_at_r", 32'(smp_instr_valid), 32'h1);
        cycle();
        check("t4_addr_r1", smp_addr, 32'h0000_0100);
        check("t4_req_valid_r1", 32'(smp_req_valid), 32'h1);
        check("t4_instr_valid_r1", 32'(smp_instr_valid), 32'h0);
        repeat (6) cycle();
        check("t4_pops", pop_log.size() >= 5, 1);
        if (pop_log.size() >= 5) begin
            check("t4_pop_at_r_pc", pop_log[3].pc, 32'h0000_008C);
            check("t4_pop_at_r_cyc", pop_log[3].cyc, 5);
            check("t4_new_pc", pop_log[4].pc, 32'h0000_0100);
            check("t4_new_cyc", pop_log[4].cyc, 8);
        end

        // 5: request channel ready one cycle in three
        lat = 2; ir_cfg = 1'b1; rr_rand = 1'b1; stall_checks = 0;
        do_reset();
        repeat (150) cycle();
        rr_rand = 1'b0;
        repeat (8) cycle();
        check("t5_pops", pop_log.size() > 20, 1);
        for (int k = 0; k < pop_log.size(); k++) begin
            check("t5_pc", pop_log[k].pc, RST_PC + 32'(4 * k));
            check("t5_data", pop_log[k].data, 32'h1000_0020 + 32'(k));
        end
        check("t5_stalls_seen", stall_checks > 0, 1);

        // 6: asynchronous reset with three entries buffered
        lat = 1; ir_cfg = 1'b0;
        do_reset();
        redir_next = 1'b1; redir_pc_v = 32'h0000_0200;
        cycle();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (fifo_q.size() == 3) found = 1'b1;
        end
        check("t6_fill", 32'(found), 32'h1);
        @(posedge clk);
        #1;
        check("t6_valid_before", 32'(instr_valid), 32'h1);
        check("t6_pc_before", instr_pc, 32'h0000_0200);
        rst_cfg = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("t6_iv_async", 32'(instr_valid), 32'h0);
        check("t6_rv_async", 32'(imem_req_valid), 32'h0);
        do_reset();
        ir_cfg = 1'b1;
        repeat (8) cycle();
        check("t6_reqs", hs_log.size() != 0, 1);
        if (hs_log.size() != 0) begin
            check("t6_first_req", hs_log[0].addr, RST_PC);
            check("t6_first_req_cyc", hs_log[0].cyc, 0);
        end
        check("t6_pops", pop_log.size() != 0, 1);
        if (pop_log.size() != 0) begin
            check("t6_first_pop", pop_log[0].pc, RST_PC);
            check("t6_first_pop_cyc", pop_log[0].cyc, 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
